acc_cpu_core: RTL and testbench

//  Parametrised accumulator CPU core: next generation of the 8-bit switch/LED teaching CPU.

---
 rtl/acc_cpu_core.sv | 141 ++++++++++++++
 tb/tb_acc_cpu_core.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: FETCH/EXECUTE/HALT sequencer with PC, accumulator, flags and
// register file. Program memory is external with asynchronous read on prog_addr.
module acc_cpu_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned PC_W   = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  output logic [PC_W-1:0]   prog_addr,
  input  logic [PC_W+3:0]   prog_data,
  input  logic [DATA_W-1:0] swiches,
  output logic [DATA_W-1:0] leds,
  output logic              carry,
  output logic              zero,
  output logic              halted,
  output logic              retire
);

  localparam int unsigned REG_AW  = $clog2(NREGS);
  localparam int unsigned INSTR_W = 4 + PC_W;

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   leds_q, leds_d;
  logic                c_q, c_d;
  logic                z_q, z_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic                reg_we;
  logic                acc_wr;

  logic [3:0]          opcode;
  logic [PC_W-1:0]     operand;
  logic [REG_AW-1:0]   r;
  logic [DATA_W-1:0]   rdata;
  logic [DATA_W:0]     sum;

  assign opcode  = ir_q[INSTR_W-1 -: 4];
  assign operand = ir_q[PC_W-1:0];
  assign r       = operand[REG_AW-1:0];
  assign rdata   = regs_q[r];
  assign sum     = {1'b0, acc_q} + {1'b0, rdata};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    leds_d  = leds_q;
    c_d     = c_q;
    z_d     = z_q;
    reg_we  = 1'b0;
    acc_wr  = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (run) begin
          ir_d    = prog_data;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_q + PC_W'(1);
        case (opcode)
          4'h1: begin acc_d = rdata; acc_wr = 1'b1; end
          4'h2: reg_we = 1'b1;
          4'h3: begin {c_d, acc_d} = sum; acc_wr = 1'b1; end
          4'h4: begin
            acc_d  = acc_q - rdata;
            c_d    = (acc_q < rdata);
            acc_wr = 1'b1;
          end
          4'h5: begin acc_d = acc_q & rdata; acc_wr = 1'b1; end
          4'h6: begin acc_d = acc_q | rdata; acc_wr = 1'b1; end
          4'h7: begin acc_d = acc_q ^ rdata; acc_wr = 1'b1; end
          4'h8: begin acc_d = swiches; acc_wr = 1'b1; end
          4'h9: leds_d = acc_q;
          4'hA: pc_d = operand;
          // Branch flags are the ones left by earlier instructions
          4'hB: if (c_q) pc_d = operand;
          4'hC: if (z_q) pc_d = operand;
          4'hD: begin acc_d = DATA_W'(operand); acc_wr = 1'b1; end
          4'hE: begin
            c_d    = acc_q[DATA_W-1];
            acc_d  = {acc_q[DATA_W-2:0], 1'b0};
            acc_wr = 1'b1;
          end
          4'hF: begin
            state_d = StHalt;
            pc_d    = pc_q;
          end
          default: ;
        endcase
        if (acc_wr) z_d = (acc_d == '0);
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      leds_q  <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      leds_q  <= leds_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[r] <= acc_q;
    end
  end

  assign prog_addr = pc_q;
  assign leds      = leds_q;
  assign carry     = c_q;
  assign zero      = z_q;
  assign halted    = (state_q == StHalt);
  assign retire    = (state_q == StExec);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: default build plus a 16-bit/8-reg/6-bit-PC build.
module tb_acc_cpu_core;

  localparam logic [3:0] OpNop = 4'h0, OpLda = 4'h1, OpSta = 4'h2, OpAdd = 4'h3;
  localparam logic [3:0] OpSub = 4'h4, OpIn  = 4'h8, OpOut = 4'h9, OpJmp = 4'hA;
  localparam logic [3:0] OpJz  = 4'hC, OpLdi = 4'hD, OpShl = 4'hE, OpHlt = 4'hF;

  logic        clk;
  logic        clr, run;
  logic [4:0]  pa1;
  logic [8:0]  pd1;
  logic [7:0]  sw1, leds1;
  logic        c1, z1, h1, ret1;
  logic [8:0]  mem1 [32];

  logic        clr2, run2;
  logic [5:0]  pa2;
  logic [9:0]  pd2;
  logic [15:0] sw2, leds2;
  logic        c2, z2, h2, ret2;
  logic [9:0]  mem2 [64];

  int          n_checks;
  int          n_fail;
  logic [7:0]  exp_q [$];
  logic [7:0]  obs_q [$];
  logic [7:0]  leds_prev;

  assign pd1 = mem1[pa1];
  assign pd2 = mem2[pa2];

  acc_cpu_core dut (
    .clk(clk), .clr(clr), .run(run), .prog_addr(pa1), .prog_data(pd1), .swiches(sw1),
    .leds(leds1), .carry(c1), .zero(z1), .halted(h1), .retire(ret1)
  );

  acc_cpu_core #(.DATA_W(16), .NREGS(8), .PC_W(6)) dut2 (
    .clk(clk), .clr(clr2), .run(run2), .prog_addr(pa2), .prog_data(pd2), .swiches(sw2),
    .leds(leds2), .carry(c2), .zero(z2), .halted(h2), .retire(ret2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] a);
    return {op, a};
  endfunction

  function automatic logic [9:0] ins2(input logic [3:0] op, input logic [5:0] a);
    return {op, a};
  endfunction

  // Advance n cycles, sampling 1 time unit after each edge; logs DUT leds updates.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (leds1 !== leds_prev && !clr) obs_q.push_back(leds1);
      leds_prev = leds1;
    end
  endtask

  task automatic apply_clr();
    run = 1'b0;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_mem1();
    for (int i = 0; i < 32; i++) mem1[i] = ins(OpNop, 5'd0);
  endtask

  task automatic test_reset();
    clear_mem1();
    apply_clr();
    n_checks++; if (pa1 !== 5'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pa1); end
    n_checks++; if (leds1 !== 8'd0) begin n_fail++; $display("FAIL reset_leds: got %0d want 0", leds1); end
    n_checks++; if ({c1, z1} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {c1, z1}); end
    n_checks++; if ({h1, ret1} !== 2'b00) begin n_fail++; $display("FAIL reset_halt_ret: got %b want 00", {h1, ret1}); end
    run = 1'b1;
    cyc(1);
    n_checks++; if (ret1 !== 1'b1) begin n_fail++; $display("FAIL first_retire: got %b want 1", ret1); end
    cyc(1);
    n_checks++; if ({ret1, pa1} !== {1'b0, 5'd1}) begin n_fail++; $display("FAIL after_nop: got ret=%b pc=%0d want ret=0 pc=1", ret1, pa1); end
    run = 1'b0;
  endtask

  task automatic test_arith();
    logic [7:0] e, o;
    clear_mem1();
    mem1[0] = ins(OpLdi, 5'd25);
    mem1[1] = ins(OpShl, 5'd0);
    mem1[2] = ins(OpShl, 5'd0);
    mem1[3] = ins(OpShl, 5'd0);
    mem1[4] = ins(OpSta, 5'd1);
    mem1[5] = ins(OpLdi, 5'd25);
    mem1[6] = ins(OpShl, 5'd0);
    mem1[7] = ins(OpShl, 5'd0);
    mem1[8] = ins(OpAdd, 5'd1);
    mem1[9] = ins(OpOut, 5'd0);
    mem1[10] = ins(OpSub, 5'd1);
    mem1[11] = ins(OpOut, 5'd0);
    mem1[12] = ins(OpHlt, 5'd0);
    apply_clr();
    exp_q.push_back(8'd44);
    exp_q.push_back(8'd100);
    run = 1'b1;
    cyc(20);
    n_checks++; if (leds1 !== 8'd44) begin n_fail++; $display("FAIL add_leds: got %0d want 44", leds1); end
    n_checks++; if ({c1, z1} !== 2'b10) begin n_fail++; $display("FAIL add_flags: got CZ=%b want 10", {c1, z1}); end
    cyc(6);
    n_checks++; if (h1 !== 1'b1) begin n_fail++; $display("FAIL arith_halt: got %b want 1", h1); end
    n_checks++; if ({c1, z1} !== 2'b10) begin n_fail++; $display("FAIL sub_flags: got CZ=%b want 10", {c1, z1}); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL arith_out_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL arith_out: got %0d want %0d", o, e); end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_io_zero();
    logic [7:0] e, o;
    clear_mem1();
    mem1[0] = ins(OpIn, 5'd0);
    mem1[1] = ins(OpJz, 5'd7);
    mem1[2] = ins(OpOut, 5'd0);
    mem1[3] = ins(OpHlt, 5'd0);
    mem1[7] = ins(OpHlt, 5'd0);
    sw1 = 8'h00;
    apply_clr();
    run = 1'b1;
    cyc(4);
    n_checks++; if (pa1 !== 5'd7) begin n_fail++; $display("FAIL jz_taken: got pc=%0d want 7", pa1); end
    n_checks++; if (z1 !== 1'b1) begin n_fail++; $display("FAIL in_zero: got %b want 1", z1); end
    sw1 = 8'h5A;
    apply_clr();
    exp_q.push_back(8'h5A);
    run = 1'b1;
    cyc(4);
    n_checks++; if (pa1 !== 5'd2) begin n_fail++; $display("FAIL jz_fall: got pc=%0d want 2", pa1); end
    n_checks++; if (z1 !== 1'b0) begin n_fail++; $display("FAIL in_nonzero: got %b want 0", z1); end
    cyc(4);
    n_checks++; if ({h1, leds1} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL io_end: got h=%b leds=%h want h=1 leds=5a", h1, leds1); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL io_out_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL io_out: got %h want %h", o, e); end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_wrap_halt();
    clear_mem1();
    mem1[0] = ins(OpJmp, 5'd31);
    mem1[1] = ins(OpHlt, 5'd0);
    mem1[31] = ins(OpNop, 5'd0);
    apply_clr();
    run = 1'b1;
    cyc(2);
    run = 1'b0;
    n_checks++; if (pa1 !== 5'd31) begin n_fail++; $display("FAIL jmp_31: got pc=%0d want 31", pa1); end
    mem1[0] = ins(OpLdi, 5'd3);
    cyc(2);
    run = 1'b1;
    cyc(2);
    n_checks++; if (pa1 !== 5'd0) begin n_fail++; $display("FAIL pc_wrap: got pc=%0d want 0", pa1); end
    cyc(3);
    n_checks++; if ({ret1, h1, pa1} !== {2'b10, 5'd1}) begin n_fail++; $display("FAIL hlt_exec: got ret=%b h=%b pc=%0d want 1 0 1", ret1, h1, pa1); end
    cyc(1);
    n_checks++; if ({h1, z1} !== 2'b10) begin n_fail++; $display("FAIL halt_entry: got h=%b z=%b want 1 0", h1, z1); end
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_checks++;
      if ({ret1, h1, pa1} !== {2'b01, 5'd1}) begin
        n_fail++;
        $display("FAIL halt_hold%0d: got ret=%b h=%b pc=%0d want 0 1 1", i, ret1, h1, pa1);
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL halt_leds: got %0d writes want 0", obs_q.size()); end
    run = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] e, o;
    clear_mem1();
    mem1[0] = ins(OpLdi, 5'd5);
    mem1[1] = ins(OpSta, 5'd2);
    mem1[2] = ins(OpLdi, 5'd9);
    mem1[3] = ins(OpLda, 5'd2);
    mem1[4] = ins(OpOut, 5'd0);
    mem1[5] = ins(OpHlt, 5'd0);
    apply_clr();
    exp_q.push_back(8'd5);
    run = 1'b1;
    cyc(4);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      n_checks++;
      if ({ret1, pa1, leds1} !== {1'b0, 5'd2, 8'd0}) begin
        n_fail++;
        $display("FAIL stall%0d: got ret=%b pc=%0d leds=%0d want 0 2 0", i, ret1, pa1, leds1);
      end
    end
    run = 1'b1;
    cyc(8);
    n_checks++; if ({h1, pa1} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL resume_end: got h=%b pc=%0d want 1 5", h1, pa1); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stall_out_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL stall_out: got %0d want %0d", o, e); end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    clear_mem1();
    mem1[0] = ins(OpLdi, 5'd7);
    mem1[1] = ins(OpSta, 5'd0);
    mem1[2] = ins(OpAdd, 5'd0);
    mem1[3] = ins(OpHlt, 5'd0);
    apply_clr();
    run = 1'b1;
    cyc(5);
    n_checks++; if (ret1 !== 1'b1) begin n_fail++; $display("FAIL add_exec: got ret=%b want 1", ret1); end
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    run = 1'b0;
    n_checks++; if ({pa1, c1, z1, ret1} !== 8'd0) begin n_fail++; $display("FAIL mid_clr: got pc=%0d c=%b z=%b ret=%b want 0", pa1, c1, z1, ret1); end
    mem1[0] = ins(OpLda, 5'd0);
    mem1[1] = ins(OpHlt, 5'd0);
    run = 1'b1;
    cyc(2);
    n_checks++; if (z1 !== 1'b1) begin n_fail++; $display("FAIL regs_cleared: got z=%b want 1", z1); end
    run = 1'b0;
  endtask

  task automatic test_wide();
    for (int i = 0; i < 64; i++) mem2[i] = ins2(OpNop, 6'd0);
    mem2[0] = ins2(OpLdi, 6'd1);
    mem2[1] = ins2(OpSta, 6'd5);
    for (int i = 2; i < 17; i++) mem2[i] = ins2(OpShl, 6'd0);
    mem2[17] = ins2(OpAdd, 6'd5);
    mem2[18] = ins2(OpShl, 6'd0);
    mem2[19] = ins2(OpOut, 6'd0);
    mem2[20] = ins2(OpHlt, 6'd0);
    sw2 = 16'h0;
    clr2 = 1'b1;
    cyc(1);
    clr2 = 1'b0;
    run2 = 1'b1;
    cyc(35);
    n_checks++; if (ret2 !== 1'b1) begin n_fail++; $display("FAIL w_add_exec: got ret=%b want 1", ret2); end
    clr2 = 1'b1;
    cyc(1);
    clr2 = 1'b0;
    n_checks++; if ({pa2, c2, z2, ret2, h2} !== 10'd0) begin n_fail++; $display("FAIL w_mid_clr: got pc=%0d c=%b z=%b ret=%b h=%b want 0", pa2, c2, z2, ret2, h2); end
    cyc(36);
    n_checks++; if ({c2, z2} !== 2'b00) begin n_fail++; $display("FAIL w_add_flags: got CZ=%b want 00", {c2, z2}); end
    cyc(2);
    n_checks++; if ({c2, z2} !== 2'b10) begin n_fail++; $display("FAIL w_shl_carry: got CZ=%b want 10", {c2, z2}); end
    cyc(4);
    n_checks++; if ({h2, leds2} !== {1'b1, 16'h0002}) begin n_fail++; $display("FAIL w_shl_leds: got h=%b leds=%h want 1 0002", h2, leds2); end
    run2 = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    leds_prev = 8'h0;
    clr = 1'b1;
    run = 1'b0;
    sw1 = 8'h0;
    clr2 = 1'b1;
    run2 = 1'b0;
    sw2 = 16'h0;
    for (int i = 0; i < 64; i++) mem2[i] = 10'h0;
    test_reset();
    test_arith();
    test_io_zero();
    test_wrap_halt();
    test_stall();
    test_reset_mid_op();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
